spi_sample_responder: RTL and testbench

SPI mode-0 target (responder) that serves buffered sample words to an external SPI initiator, the opposite end of the ADC-reading SPI initiator path in the design. Parallel-side logic pushes DATA_W-bit samples into a small FIFO; each chip-select frame pops one word and shifts it out MSB-first on MISO while capturing the MOSI word. The block runs entirely on the system clock, oversampling the asynchronous SPI pins, and sits beside the initiator in the top level so the bench can loop the two ends together.

---
 rtl/spi_sample_responder.sv | 193 +++++++++++++++++++
 tb/tb_spi_sample_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_responder.sv
// spi_sample_responder: SPI mode-0 target that pops one FIFO sample per
// chip-select frame and shifts it out MSB-first on MISO while capturing MOSI.
// Ports: clk_i/reset_i (sync, active-high); in_data_i/in_valid_i/in_ready_o
// push side; sclk_i/cs_n_i/mosi_i async SPI pins; miso_o; rx_data_o/rx_valid_o
// received word; underrun_o/abort_o event pulses; level_o FIFO occupancy.
// Option: define SPI_RESP_PARITY_EN for an extra even-parity bit per frame.
module spi_sample_responder #(
    parameter int DATA_W      = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          sclk_i,
    input  logic                          cs_n_i,
    input  logic                          mosi_i,
    output logic                          miso_o,
    output logic [DATA_W-1:0]             rx_data_o,
    output logic                          rx_valid_o,
    output logic                          underrun_o,
    output logic                          abort_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

`ifdef SPI_RESP_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Pin synchronizers; cs resets low so a chip select already asserted
    // when reset releases never looks like a fresh frame start.
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    // TX sample FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    assign in_ready_o = (level_o != FULL);
    assign push       = in_valid_i & in_ready_o;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= in_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level_o <= level_o + 1'b1;
                2'b01:   level_o <= level_o - 1'b1;
                default: level_o <= level_o;
            endcase
        end
    end

    // Frame shift registers and parity handling
    logic [FRAME_W-1:0] tx_sr, rx_sr, head_frame;
    logic [DATA_W-1:0]  rx_word;
    logic               rx_ok;
    logic [CNT_W-1:0]   bit_cnt;

`ifdef SPI_RESP_PARITY_EN
    assign head_frame = {head, ^head};
    assign rx_word    = rx_sr[FRAME_W-1:1];
    assign rx_ok      = ~(^rx_sr);
`else
    assign head_frame = head;
    assign rx_word    = rx_sr;
    assign rx_ok      = 1'b1;
`endif

    // FSM
    state_t state, state_next;
    logic   start, shift_rx, shift_tx, cut, good, bad, underrun;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        cut        = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    cut        = 1'b1;
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = DONE;
                end else if (sclk_fall) begin
                    shift_tx = 1'b1;
                end
            end
            DONE: begin
                good       = rx_ok;
                bad        = ~rx_ok;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop      = start & (level_o != '0);
    assign underrun = start & (level_o == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            miso_o     <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            underrun_o <= 1'b0;
            abort_o    <= 1'b0;
        end else begin
            underrun_o <= underrun;
            abort_o    <= cut | bad;
            rx_valid_o <= good;
            miso_o     <= (state != IDLE) ? tx_sr[FRAME_W-1] : 1'b0;
            if (start) begin
                tx_sr   <= pop ? head_frame : '0;
                rx_sr   <= '0;
                bit_cnt <= '0;
            end
            if (shift_rx) begin
                rx_sr   <= {rx_sr[FRAME_W-2:0], mosi_s};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_tx) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            if (good) rx_data_o <= rx_word;
        end
    end

endmodule

// File: tb/tb_spi_sample_responder.sv
// tb_spi_sample_responder: randomized self-checking bench for the SPI
// sample responder, with a queue-based FIFO and frame model.
module tb_spi_sample_responder;
    localparam int DATA_W      = 12;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;
`ifdef SPI_RESP_PARITY_EN
    localparam int FW = DATA_W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FW = DATA_W;
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              underrun;
    logic              abort_p;
    logic [LW-1:0]     level;

    always #5 clk = ~clk;

    spi_sample_responder #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi), .miso_o(miso),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .underrun_o(underrun), .abort_o(abort_p), .level_o(level)
    );

    int errors = 0;
    int checks = 0;
    int n_valid = 0, n_under = 0, n_abort = 0;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (underrun) n_under++;
        if (abort_p)  n_abort++;
    end

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_rx = '0;

    function automatic logic [FW-1:0] frame_of(input logic [DATA_W-1:0] w);
`ifdef SPI_RESP_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic push_word(input logic [DATA_W-1:0] w);
        logic exp_rdy;
        @(negedge clk);
        exp_rdy  = (q.size() < FIFO_DEPTH);
        in_data  = w;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL push_ready got=%b exp=%b", in_ready, exp_rdy);
        end
        if (exp_rdy) q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (level !== LW'(q.size())) begin
            errors++;
            $display("FAIL push_level got=%0d exp=%0d", level, q.size());
        end
    endtask

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        repeat (5) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [FW-1:0] tx_bits, input int nbits,
                             output logic [FW-1:0] rx_bits);
        logic b;
        @(negedge clk);
        cs_n = 1'b0;
        rx_bits = '0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(tx_bits[FW-1-i], b);
            rx_bits[FW-1-i] = b;
        end
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // One frame against the model: pops the queue, checks MISO bits,
    // event pulses, captured word and FIFO level.
    task automatic do_frame(input logic [DATA_W-1:0] data, input int nbits,
                            input bit bad_par);
        logic [DATA_W-1:0] w;
        logic [FW-1:0]     tx_bits, got, exp_bits, diff;
        bit                und;
        int                v0, u0, a0, exp_v, exp_a;
        und = (q.size() == 0);
        w   = und ? '0 : q.pop_front();
        tx_bits = frame_of(data);
        if (bad_par) tx_bits = tx_bits ^ FW'(1);
        exp_bits = frame_of(w);
        v0 = n_valid; u0 = n_under; a0 = n_abort;
        spi_frame(tx_bits, nbits, got);
        diff = (got ^ exp_bits) >> (FW - nbits);
        checks++;
        if (diff !== '0) begin
            errors++;
            $display("FAIL miso_word got=%0h exp=%0h bits=%0d", got, exp_bits, nbits);
        end
        checks++;
        if ((n_under - u0) !== int'(und)) begin
            errors++;
            $display("FAIL underrun_count got=%0d exp=%0d", n_under - u0, und);
        end
        if (nbits == FW && !bad_par) begin
            exp_v = 1; exp_a = 0; exp_rx = data;
        end else begin
            exp_v = 0; exp_a = 1;
        end
        checks++;
        if ((n_valid - v0) !== exp_v) begin
            errors++;
            $display("FAIL rx_valid_count got=%0d exp=%0d", n_valid - v0, exp_v);
        end
        checks++;
        if ((n_abort - a0) !== exp_a) begin
            errors++;
            $display("FAIL abort_count got=%0d exp=%0d", n_abort - a0, exp_a);
        end
        checks++;
        if (rx_data !== exp_rx) begin
            errors++;
            $display("FAIL rx_data got=%0h exp=%0h", rx_data, exp_rx);
        end
        checks++;
        if (miso !== 1'b0 || level !== LW'(q.size())) begin
            errors++;
            $display("FAIL idle_state miso=%b level=%0d exp_level=%0d", miso, level, q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || miso !== 1'b0 || rx_data !== '0 ||
            rx_valid !== 1'b0 || underrun !== 1'b0 || abort_p !== 1'b0 ||
            level !== '0) begin
            errors++;
            $display("FAIL reset_values rdy=%b miso=%b rx=%0h v=%b u=%b a=%b lvl=%0d",
                     in_ready, miso, rx_data, rx_valid, underrun, abort_p, level);
        end
    endtask

    task automatic test_basic;
        push_word(12'hA5C);
        do_frame(12'h3F1, FW, 1'b0);
    endtask

    task automatic test_fill;
        for (int i = 0; i < 5; i++) push_word(DATA_W'($urandom));
        checks++;
        if (in_ready !== 1'b0 || level !== LW'(FIFO_DEPTH)) begin
            errors++;
            $display("FAIL fill_full rdy=%b level=%0d", in_ready, level);
        end
        for (int i = 0; i < 4; i++) do_frame(DATA_W'($urandom), FW, 1'b0);
    endtask

    task automatic test_underrun;
        do_frame(DATA_W'($urandom), FW, 1'b0);
    endtask

    task automatic test_abort;
        push_word(DATA_W'($urandom));
        push_word(DATA_W'($urandom));
        do_frame(DATA_W'($urandom), 7, 1'b0);
        do_frame(DATA_W'($urandom), FW, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic b;
        int   a0;
        push_word(DATA_W'($urandom));
        a0 = n_abort;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), b);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || miso !== 1'b0 || rx_data !== '0 ||
            rx_valid !== 1'b0 || underrun !== 1'b0 || abort_p !== 1'b0 ||
            level !== '0) begin
            errors++;
            $display("FAIL midframe_reset rdy=%b miso=%b rx=%0h v=%b u=%b a=%b lvl=%0d",
                     in_ready, miso, rx_data, rx_valid, underrun, abort_p, level);
        end
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_rx = '0;
        repeat (8) @(negedge clk);
        checks++;
        if (n_abort !== a0 || level !== '0) begin
            errors++;
            $display("FAIL midframe_no_abort aborts=%0d exp=%0d level=%0d",
                     n_abort - a0, 0, level);
        end
    endtask

    task automatic test_parity;
        push_word(DATA_W'($urandom));
        do_frame(12'h001, FW, 1'b0);
        push_word(DATA_W'($urandom));
        do_frame(12'h001, FW, 1'b1);
    endtask

    task automatic test_random;
        int k, nb;
        bit bp;
        for (int it = 0; it < 10; it++) begin
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) push_word(DATA_W'($urandom));
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FW - 1) : FW;
            bp = PAR && (nb == FW) && ($urandom_range(0, 3) == 0);
            do_frame(DATA_W'($urandom), nb, bp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underrun();
        test_abort();
        test_reset_mid();
`ifdef SPI_RESP_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
